// File: rtl/icache_pkg.sv
// Shared FSM states, AHB encodings and a clog2 helper for the N-way icache.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_REQ    = 3'd2,
    S_FILL   = 3'd3,
    S_RESP   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/icache_tag_cmp.sv
// Combinational per-way tag compare for one set: one-hot hit vector plus encoded hit way.
module icache_tag_cmp #(
  parameter int WAYS  = 4,
  parameter int TAG_W = 15,
  parameter int WAY_W = 2
) (
  input  logic [WAYS-1:0][TAG_W-1:0] way_tag,
  input  logic [WAYS-1:0]            way_vld,
  input  logic [TAG_W-1:0]           tag,
  output logic [WAYS-1:0]            hit_oh,
  output logic [WAY_W-1:0]           hit_idx
);

  always_comb begin
    hit_oh  = '0;
    hit_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_oh[w] = way_vld[w] && (way_tag[w] == tag);
      if (hit_oh[w]) hit_idx = WAY_W'(w);
    end
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only icache: AHB-lite slave, line refill master, round-robin replacement.
// Optional ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_nway
  import icache_pkg::*;
#(
  parameter int AW         = 20,
  parameter int WAYS       = 4,
  parameter int SETS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hsel,
  input  logic [1:0]    htrans,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic          hwrite,
  input  logic [AW-1:0] haddr,
  input  logic [31:0]   hwdata,
  output logic [31:0]   hrdata,
  output logic          hready_out,
  output logic          hresp,
  input  logic          flush,
  output logic          req,
  output logic [AW-1:0] c_addr,
  input  logic          ack,
  input  logic          valid,
  input  logic [31:0]   data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  localparam int OFF_W = clog2(LINE_WORDS);
  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = AW - 2 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? clog2(WAYS) : 1;

  state_e                      state_q, state_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [WAY_W-1:0]            victim_q, victim_d;
  logic [OFF_W-1:0]            cnt_q, cnt_d;
  logic [31:0]                 hrdata_q, hrdata_d;
  logic [AW-1:0]               c_addr_q, c_addr_d;
  logic                        flush_pend_q, flush_pend_d;
  logic [WAYS-1:0][TAG_W-1:0]  tag_q [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_d [SETS];
  logic [WAYS-1:0]             valid_q [SETS];
  logic [WAYS-1:0]             valid_d [SETS];
  logic [31:0]                 data_q [SETS][WAYS][LINE_WORDS];
  logic [31:0]                 data_d [SETS][WAYS][LINE_WORDS];
  logic [WAY_W-1:0]            rr_q [SETS];
  logic [WAY_W-1:0]            rr_d [SETS];

  logic [OFF_W-1:0] word_w;
  logic [IDX_W-1:0] idx_w;
  logic [TAG_W-1:0] tag_w;
  logic [WAYS-1:0]  hit_oh;
  logic [WAY_W-1:0] hit_idx;
  logic [WAY_W-1:0] vict;
  logic [31:0]      hit_word;
  logic             lookup_hit;
  logic             accept;
  logic             unused_ok;

  assign word_w    = addr_q[OFF_W+1:2];
  assign idx_w     = addr_q[OFF_W+2 +: IDX_W];
  assign tag_w     = addr_q[AW-1 -: TAG_W];
  assign unused_ok = ^{hsize, hburst, hwdata, htrans[0], addr_q[1:0]};

  icache_tag_cmp #(.WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_tag_cmp (
    .way_tag (tag_q[idx_w]),
    .way_vld (valid_q[idx_w]),
    .tag     (tag_w),
    .hit_oh  (hit_oh),
    .hit_idx (hit_idx)
  );

  assign hit_word   = data_q[idx_w][hit_idx][word_w];
  // A flush in the lookup cycle must not hand out data from a line it is invalidating.
  assign lookup_hit = (state_q == S_LOOKUP) && (|hit_oh) && !flush;

  always_comb begin
    hready_out = 1'b1;
    hrdata     = hrdata_q;
    if (state_q == S_LOOKUP) begin
      hready_out = lookup_hit;
      hrdata     = lookup_hit ? hit_word : '0;
    end else if (state_q inside {S_REQ, S_FILL, S_ERR1}) begin
      hready_out = 1'b0;
    end
  end

  assign hresp  = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign req    = (state_q == S_REQ);
  assign c_addr = c_addr_q;
  assign accept = hsel && htrans[1] && hready_out;

  // Lowest-index invalid way wins, otherwise the set's round-robin pointer.
  always_comb begin
    vict = rr_q[idx_w];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_w][w]) vict = WAY_W'(w);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    victim_d     = victim_q;
    cnt_d        = cnt_q;
    hrdata_d     = hrdata_q;
    c_addr_d     = c_addr_q;
    flush_pend_d = flush_pend_q | flush;
    tag_d        = tag_q;
    valid_d      = valid_q;
    data_d       = data_q;
    rr_d         = rr_q;

    case (state_q)
      S_IDLE, S_RESP, S_ERR2: state_d = S_IDLE;
      S_LOOKUP: begin
        state_d = S_IDLE;
        if (!lookup_hit) begin
          state_d      = S_REQ;
          victim_d     = vict;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
          c_addr_d     = {addr_q[AW-1:OFF_W+2], {(OFF_W+2){1'b0}}};
        end
      end
      S_REQ:  if (ack) state_d = S_FILL;
      S_FILL: begin
        if (valid) begin
          data_d[idx_w][victim_q][cnt_q] = data;
          if (cnt_q == word_w) hrdata_d = data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            state_d = S_RESP;
            tag_d[idx_w][victim_q] = tag_w;
            if (!flush_pend_q) valid_d[idx_w][victim_q] = 1'b1;
            rr_d[idx_w] = (rr_q[idx_w] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_w] + 1'b1;
          end
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      addr_d  = haddr;
      state_d = hwrite ? S_ERR1 : S_LOOKUP;
    end

    if (flush) begin
      for (int s = 0; s < SETS; s++) valid_d[s] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      victim_q     <= '0;
      cnt_q        <= '0;
      hrdata_q     <= '0;
      c_addr_q     <= '0;
      flush_pend_q <= 1'b0;
      tag_q        <= '{default: '0};
      valid_q      <= '{default: '0};
      data_q       <= '{default: '0};
      rr_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      victim_q     <= victim_d;
      cnt_q        <= cnt_d;
      hrdata_q     <= hrdata_d;
      c_addr_q     <= c_addr_d;
      flush_pend_q <= flush_pend_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      rr_q         <= rr_d;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_hit) begin
      if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
    end else if (state_q == S_LOOKUP) begin
      if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: scoreboard of expected read data, popped at each data-phase completion.
module tb_icache_nway;
  import icache_pkg::*;

  localparam int AW         = 20;
  localparam int LINE_WORDS = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          hsel = 1'b0;
  logic [1:0]    htrans = HTRANS_IDLE;
  logic [2:0]    hsize = 3'd2;
  logic [2:0]    hburst = 3'd0;
  logic          hwrite = 1'b0;
  logic [AW-1:0] haddr = '0;
  logic [31:0]   hwdata = '0;
  logic [31:0]   hrdata;
  logic          hready_out;
  logic          hresp;
  logic          flush = 1'b0;
  logic          req;
  logic [AW-1:0] c_addr;
  logic          ack = 1'b0;
  logic          valid = 1'b0;
  logic [31:0]   data = '0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  icache_nway #(.AW(AW), .WAYS(4), .SETS(2), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .hsel(hsel), .htrans(htrans), .hsize(hsize),
    .hburst(hburst), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata), .hready_out(hready_out), .hresp(hresp), .flush(flush),
    .req(req), .c_addr(c_addr), .ack(ack), .valid(valid), .data(data)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Backing memory: every word holds 0x90 + word address (line 0x40 -> 0xA0..0xA3).
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h90 + 32'(a >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, hrdata, e);
    end
  endtask

  // fl: 0 none, 1 flush in the lookup cycle, 2 flush during the second refill beat.
  task automatic do_read(input string nm, input logic [AW-1:0] a, input bit miss, input int fl);
    logic [AW-1:0] base;
    int n;
    base = {a[AW-1:4], 4'h0};
    check({nm, "_rdy_addr"}, 32'(hready_out), 32'd1);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = a;
    exp_q.push_back(mem_word(a));
    step();
    hsel = 1'b0; htrans = HTRANS_IDLE;
    if (fl == 1) begin
      flush = 1'b1;
      #1;
    end
    check({nm, "_rdy_lookup"}, 32'(hready_out), miss ? 32'd0 : 32'd1);
    if (!miss) begin
      pop_check({nm, "_hit_data"});
      check({nm, "_hit_noreq"}, 32'(req), 32'd0);
      step();
    end else begin
      n = 0;
      while (!req && n < 20) begin
        step();
        flush = 1'b0;
        n++;
      end
      check({nm, "_req"}, 32'(req), 32'd1);
      check({nm, "_c_addr"}, 32'(c_addr), 32'(base));
      ack = 1'b1;
      step();
      ack = 1'b0;
      check({nm, "_req_drop"}, 32'(req), 32'd0);
      check({nm, "_rdy_fill"}, 32'(hready_out), 32'd0);
      for (int k = 0; k < LINE_WORDS; k++) begin
        valid = 1'b1;
        data  = mem_word(base + AW'(4 * k));
        if (fl == 2 && k == 1) flush = 1'b1;
        step();
        flush = 1'b0;
      end
      valid = 1'b0; data = '0;
      check({nm, "_rdy_resp"}, 32'(hready_out), 32'd1);
      pop_check({nm, "_fill_data"});
      check({nm, "_hresp"}, 32'(hresp), 32'd0);
      step();
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_hready", 32'(hready_out), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_c_addr", 32'(c_addr), 32'd0);
    reset_n = 1'b1;
    step();

    do_read("t1_cold", 20'h00040, 1'b1, 0);
    do_read("t2_hit", 20'h00044, 1'b0, 0);
`ifdef ICACHE_PERF_CNT_EN
    check("t6_miss_cnt", miss_cnt, 32'd1);
    check("t6_hit_cnt", hit_cnt, 32'd1);
`endif

    do_read("t3_f2", 20'h00080, 1'b1, 0);
    do_read("t3_f3", 20'h000C0, 1'b1, 0);
    do_read("t3_f4", 20'h00100, 1'b1, 0);
    do_read("t3_f5", 20'h00140, 1'b1, 0);
    do_read("t3_2nd_hit", 20'h00084, 1'b0, 0);
    do_read("t3_1st_miss", 20'h00048, 1'b1, 0);

    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 20'h00010;
    step();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    check("t4_err1_hresp", 32'(hresp), 32'd1);
    check("t4_err1_rdy", 32'(hready_out), 32'd0);
    step();
    check("t4_err2_hresp", 32'(hresp), 32'd1);
    check("t4_err2_rdy", 32'(hready_out), 32'd1);
    step();
    check("t4_idle_hresp", 32'(hresp), 32'd0);
    do_read("t4_rd_cold", 20'h00010, 1'b1, 0);

    do_read("t5_flush_fill", 20'h00084, 1'b1, 2);
    do_read("t5_refetch", 20'h00080, 1'b1, 0);
    do_read("t5_hit", 20'h0008C, 1'b0, 0);
    do_read("t5_flush_lookup", 20'h00088, 1'b1, 1);
    do_read("t5_after", 20'h00080, 1'b0, 0);

    // Abandon a refill halfway with an asynchronous reset.
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 20'h000C0;
    step();
    hsel = 1'b0; htrans = HTRANS_IDLE;
    n = 0;
    while (!req && n < 20) begin
      step();
      n++;
    end
    check("t6_req", 32'(req), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid = 1'b1;
      data  = mem_word(20'h000C0 + AW'(4 * k));
      step();
    end
    valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t6_rst_req", 32'(req), 32'd0);
    check("t6_rst_rdy", 32'(hready_out), 32'd1);
    check("t6_rst_hrdata", hrdata, 32'd0);
    check("t6_rst_c_addr", 32'(c_addr), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("t6_rst_hit_cnt", hit_cnt, 32'd0);
    check("t6_rst_miss_cnt", miss_cnt, 32'd0);
`endif
    exp_q.delete();
    step();
    reset_n = 1'b1;
    step();
    do_read("t6_after_rst", 20'h000C4, 1'b1, 0);
    do_read("t6_old_line", 20'h00040, 1'b1, 0);
`ifdef ICACHE_PERF_CNT_EN
    check("t6_post_miss_cnt", miss_cnt, 32'd2);
    check("t6_post_hit_cnt", hit_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
